// File: rtl/peripheral_axi4_pkg.sv
// Shared AHB-Lite encodings plus the APB4->AHB-Lite bridge state type.
package peripheral_axi4_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [3:0] HPROT_DATA = 4'b0001;
    localparam logic [3:0] HPROT_PRIV = 4'b0010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } apb42ahb_state_t;

endpackage

// File: rtl/peripheral_apb42ahb_if.sv
// APB4 slave + AHB-Lite master signal bundle for the APB4->AHB-Lite bridge.
interface peripheral_apb42ahb_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 12
);
    logic                    PSEL;
    logic                    PENABLE;
    logic [2:0]              PPROT;
    logic                    PWRITE;
    logic [HDATA_SIZE/8-1:0] PSTRB;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic [HDATA_SIZE-1:0]   PWDATA;
    logic [HDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    logic                    HSEL;
    logic [HADDR_SIZE-1:0]   HADDR;
    logic [HDATA_SIZE-1:0]   HWDATA;
    logic [HDATA_SIZE-1:0]   HRDATA;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [3:0]              HPROT;
    logic [1:0]              HTRANS;
    logic                    HMASTLOCK;
    logic                    HREADY;
    logic                    HRESP;

    // Bridge side: APB slave facing the controller, AHB master facing the fabric.
    modport slave (
        input  PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport master (
        output PSEL, PENABLE, PPROT, PWRITE, PSTRB, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/peripheral_apb42ahb_strb_decode.sv
// Combinational PSTRB decoder: legality, beat size, lowest-lane offset, lanes left after a byte beat.
import peripheral_axi4_pkg::*;

module peripheral_apb42ahb_strb_decode (
    input  logic [3:0] i_strb,
    output logic       o_legal,
    output logic [2:0] o_size,
    output logic [1:0] o_off,
    output logic [3:0] o_rest
);
    always_comb begin
        o_legal = 1'b1;
        o_size  = HSIZE_BYTE;
        unique case (i_strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = HSIZE_BYTE;
            4'b0011, 4'b1100:                   o_size = HSIZE_HWORD;
            4'b1111:                            o_size = HSIZE_WORD;
            default:                            o_legal = 1'b0;
        endcase
    end

    // Every legal pattern starts at its lowest set lane, so one priority chain serves both uses.
    always_comb begin
        o_off = 2'd0;
        if (i_strb[0])      o_off = 2'd0;
        else if (i_strb[1]) o_off = 2'd1;
        else if (i_strb[2]) o_off = 2'd2;
        else if (i_strb[3]) o_off = 2'd3;
    end

    assign o_rest = i_strb & (i_strb - 4'd1);
endmodule

// File: rtl/peripheral_apb42ahb.sv
// APB4 slave to AHB-Lite master bridge (SINGLE beats only).
// Define PERIPHERAL_APB42AHB_SPLIT_EN to split sparse write strobes into byte beats.
import peripheral_axi4_pkg::*;

module peripheral_apb42ahb #(
    parameter int                    HADDR_SIZE = 32,
    parameter int                    HDATA_SIZE = 32,
    parameter int                    PADDR_SIZE = 12,
    parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0
) (
    input logic                  PCLK,
    input logic                  PRESET,
    peripheral_apb42ahb_if.slave bus
);
    apb42ahb_state_t         r_state, w_next;
    logic [PADDR_SIZE-3:0]   r_addr;
    logic                    r_write;
    logic [HDATA_SIZE-1:0]   r_wdata;
    logic [1:0]              r_prot;
    logic [3:0]              r_mask;
    logic [2:0]              r_size;
    logic [1:0]              r_off;
    logic                    r_err;
    logic [HDATA_SIZE-1:0]   r_rdata;

    logic                    w_setup;
    logic [3:0]              w_dec_in;
    logic                    w_dec_legal;
    logic [2:0]              w_dec_size;
    logic [1:0]              w_dec_off;
    logic [3:0]              w_dec_rest;
    logic [HADDR_SIZE-1:0]   w_haddr;

    assign w_setup  = bus.PSEL & ~bus.PENABLE;
    // Outside IDLE the decoder walks the lanes still owed by a split write.
    assign w_dec_in = (r_state == IDLE) ? bus.PSTRB : r_mask;

    peripheral_apb42ahb_strb_decode u_strb_decode (
        .i_strb  (w_dec_in),
        .o_legal (w_dec_legal),
        .o_size  (w_dec_size),
        .o_off   (w_dec_off),
        .o_rest  (w_dec_rest)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_setup) begin
                if (!bus.PWRITE)            w_next = ADDR;
                else if (bus.PSTRB == '0)   w_next = RESP;
                else if (w_dec_legal)       w_next = ADDR;
                else begin
`ifdef PERIPHERAL_APB42AHB_SPLIT_EN
                    w_next = ADDR;
`else
                    w_next = RESP;
`endif
                end
            end
            ADDR: if (bus.HREADY) w_next = DATA;
            DATA: if (bus.HREADY) begin
                if (bus.HRESP == HRESP_ERROR || r_err || r_mask == '0) w_next = RESP;
                else                                                  w_next = ADDR;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_write <= 1'b0;
            r_mask  <= '0;
            r_size  <= HSIZE_BYTE;
            r_off   <= 2'd0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (w_setup) begin
                    r_addr  <= bus.PADDR[PADDR_SIZE-1:2];
                    r_write <= bus.PWRITE;
                    r_wdata <= bus.PWDATA;
                    r_prot  <= {bus.PPROT[2], bus.PPROT[0]};
                    r_err   <= 1'b0;
                    r_mask  <= '0;
                    r_size  <= w_dec_size;
                    r_off   <= w_dec_off;
                    if (!bus.PWRITE) begin
                        r_size <= HSIZE_WORD;
                        r_off  <= 2'd0;
                    end else if (bus.PSTRB != '0 && !w_dec_legal) begin
`ifdef PERIPHERAL_APB42AHB_SPLIT_EN
                        r_size <= HSIZE_BYTE;
                        r_mask <= w_dec_rest;
`else
                        r_err  <= 1'b1;
`endif
                    end
                end
                DATA: begin
                    if (bus.HRESP == HRESP_ERROR) begin
                        r_err  <= 1'b1;
                        r_mask <= '0;
                    end else if (bus.HREADY && !r_err) begin
                        if (!r_write) r_rdata <= bus.HRDATA;
                        if (r_mask != '0) begin
                            r_off  <= w_dec_off;
                            r_size <= HSIZE_BYTE;
                            r_mask <= w_dec_rest;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_haddr = HADDR_BASE | HADDR_SIZE'({r_addr, r_off});

    assign bus.HSEL      = (r_state == ADDR);
    assign bus.HTRANS    = (r_state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR     = (r_state == ADDR) ? w_haddr : '0;
    assign bus.HWRITE    = (r_state == ADDR) & r_write;
    assign bus.HSIZE     = (r_state == ADDR) ? r_size : HSIZE_BYTE;
    assign bus.HPROT     = (r_state != ADDR) ? 4'b0000 :
                           ((r_prot[1] ? 4'b0000 : HPROT_DATA) | (r_prot[0] ? HPROT_PRIV : 4'b0000));
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = (r_state == DATA && r_write) ? r_wdata : '0;

    assign bus.PREADY  = (r_state == RESP);
    assign bus.PSLVERR = (r_state == RESP) & r_err;
    assign bus.PRDATA  = r_rdata;
endmodule

// File: tb/tb_peripheral_apb42ahb.sv
// Directed scoreboard bench for the APB4->AHB-Lite bridge (both split builds).
module tb_peripheral_apb42ahb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    peripheral_apb42ahb_if #(.HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(12)) bus ();

    peripheral_apb42ahb #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(12), .HADDR_BASE(32'h0)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    typedef struct {
        int          lat;
        logic        slverr;
        logic        chk_rd;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
    } beat_t;

    resp_t rq[$];
    beat_t bq[$];
    int    n_checks = 0;
    int    n_errors = 0;
    bit    in_data;
    int    dcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [2:0] s, input logic w);
        beat_t b;
        b.addr = a; b.size = s; b.wr = w;
        bq.push_back(b);
    endtask

    task automatic xfer(input logic wr, input logic [11:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input int wait_n, input bit err,
                        input logic [31:0] rd, input int exp_lat, input logic exp_err);
        resp_t e;
        resp_t r;
        beat_t b;
        int    cyc;
        bit    got;
        e.lat = exp_lat; e.slverr = exp_err; e.chk_rd = !wr; e.rdata = rd;
        rq.push_back(e);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr;
        bus.PSTRB = strb; bus.PWDATA = wd; bus.PPROT = 3'b001;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        in_data = 0; dcnt = 0; cyc = 0; got = 0;
        while (!got && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            bus.PENABLE = 1'b1;
            if (in_data) begin
                bus.HRESP  = err;
                bus.HREADY = err ? (dcnt >= 1) : (dcnt >= wait_n);
                bus.HRDATA = rd;
            end else begin
                bus.HRESP  = 1'b0;
                bus.HREADY = 1'b1;
                bus.HRDATA = 32'hBAD0_BAD0;
            end
            @(negedge clk);
            if (in_data) begin
                if (wr) chk("hwdata", bus.HWDATA, wd);
                if (bus.HREADY) in_data = 0;
                else            dcnt++;
            end else if (bus.HTRANS == 2'b10) begin
                chk("hprot", 32'(bus.HPROT), 32'h3);
                chk("hsel", 32'(bus.HSEL), 32'h1);
                if (bq.size() == 0) begin
                    chk("beat_unexpected", bus.HADDR, 32'hFFFF_FFFF);
                end else begin
                    b = bq.pop_front();
                    chk("haddr", bus.HADDR, b.addr);
                    chk("hsize", 32'(bus.HSIZE), 32'(b.size));
                    chk("hwrite", 32'(bus.HWRITE), 32'(b.wr));
                end
                in_data = 1; dcnt = 0;
            end
            if (bus.PREADY) begin
                got = 1;
                r = rq.pop_front();
                chk("latency", 32'(cyc), 32'(r.lat));
                chk("pslverr", 32'(bus.PSLVERR), 32'(r.slverr));
                if (r.chk_rd) chk("prdata", bus.PRDATA, r.rdata);
            end else begin
                chk("pslverr_low", 32'(bus.PSLVERR), 32'h0);
            end
        end
        if (!got) begin
            chk("pready_timeout", 32'(cyc), 32'(exp_lat));
            void'(rq.pop_front());
        end
        chk("beats_left", 32'(bq.size()), 32'h0);
        bq.delete();
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge clk);
        chk("pready_one_cycle", 32'(bus.PREADY), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PPROT = 3'b000; bus.PWRITE = 1'b0;
        bus.PSTRB = 4'h0; bus.PADDR = 12'h0; bus.PWDATA = 32'h0;
        bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
        chk("rst_hsel", 32'(bus.HSEL), 32'h0);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_pready", 32'(bus.PREADY), 32'h0);
        chk("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
        chk("rst_prdata", bus.PRDATA, 32'h0);
        chk("rst_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
        chk("rst_hburst", 32'(bus.HBURST), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        push_beat(32'h010, 3'd2, 1'b0);
        xfer(1'b0, 12'h010, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF, 3, 1'b0);
        push_beat(32'h022, 3'd0, 1'b1);
        xfer(1'b1, 12'h020, 4'b0100, 32'h00AB0000, 0, 0, 32'h0, 3, 1'b0);
        push_beat(32'h034, 3'd2, 1'b1);
        xfer(1'b1, 12'h034, 4'b1111, 32'h12345678, 3, 0, 32'h0, 6, 1'b0);
        push_beat(32'h040, 3'd1, 1'b1);
        xfer(1'b1, 12'h040, 4'b0011, 32'h0000BEEF, 0, 0, 32'h0, 3, 1'b0);
        push_beat(32'h046, 3'd1, 1'b1);
        xfer(1'b1, 12'h044, 4'b1100, 32'hFACE0000, 0, 0, 32'h0, 3, 1'b0);
        push_beat(32'h04B, 3'd0, 1'b1);
        xfer(1'b1, 12'h048, 4'b1000, 32'h5A000000, 1, 0, 32'h0, 4, 1'b0);
        push_beat(32'h050, 3'd2, 1'b1);
        xfer(1'b1, 12'h050, 4'b1111, 32'hA5A5A5A5, 0, 1, 32'h0, 4, 1'b1);
        push_beat(32'h054, 3'd2, 1'b0);
        xfer(1'b0, 12'h056, 4'h0, 32'h0, 0, 0, 32'hCAFEF00D, 3, 1'b0);
        xfer(1'b1, 12'h05C, 4'b0000, 32'h11111111, 0, 0, 32'h0, 1, 1'b0);

`ifdef PERIPHERAL_APB42AHB_SPLIT_EN
        push_beat(32'h060, 3'd0, 1'b1);
        push_beat(32'h062, 3'd0, 1'b1);
        xfer(1'b1, 12'h060, 4'b0101, 32'h00CC00DD, 0, 0, 32'h0, 5, 1'b0);
        push_beat(32'h064, 3'd0, 1'b1);
        push_beat(32'h065, 3'd0, 1'b1);
        push_beat(32'h067, 3'd0, 1'b1);
        xfer(1'b1, 12'h064, 4'b1011, 32'h44003322, 0, 0, 32'h0, 7, 1'b0);
        push_beat(32'h069, 3'd0, 1'b1);
        xfer(1'b1, 12'h068, 4'b0110, 32'h00EEFF00, 0, 1, 32'h0, 4, 1'b1);
`else
        xfer(1'b1, 12'h060, 4'b0101, 32'h00CC00DD, 0, 0, 32'h0, 1, 1'b1);
        xfer(1'b1, 12'h064, 4'b1011, 32'h44003322, 0, 0, 32'h0, 1, 1'b1);
        xfer(1'b1, 12'h068, 4'b0110, 32'h00EEFF00, 0, 1, 32'h0, 1, 1'b1);
`endif

        // Reset lands while the beat is in its data phase with HREADY high.
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 12'h070;
        bus.PSTRB = 4'hF; bus.PWDATA = 32'h0F0F0F0F; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(negedge clk);
        chk("rstdata_addr_htrans", 32'(bus.HTRANS), 32'h2);
        @(posedge clk); #1;
        bus.HREADY = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("rstdata_hwdata", bus.HWDATA, 32'h0F0F0F0F);
        @(posedge clk); #1;
        rst = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        @(negedge clk);
        chk("rstdata_htrans", 32'(bus.HTRANS), 32'h0);
        chk("rstdata_pready", 32'(bus.PREADY), 32'h0);
        chk("rstdata_pslverr", 32'(bus.PSLVERR), 32'h0);

        push_beat(32'h07C, 3'd2, 1'b0);
        xfer(1'b0, 12'h07C, 4'h0, 32'h0, 0, 0, 32'h13579BDF, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
